dma_desc_sequencer: RTL

- Parametrised descriptor-chain sequencer for the DMA subsystem.
- Sits between the CSR block (go/abort/max_burst, descriptor arrays) and the single-transfer DMA engine.
- Walks NUM_DESC descriptors in index order, issuing each enabled, non-empty one to the engine over a valid/ready handshake.
- Collects per-descriptor completion, captures the first error, supports abort, and reports chain done/error status back to the CSRs.

---
 rtl/dma_desc_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dma_desc_sequencer.sv
// Descriptor-chain sequencer: walks NUM_DESC CSR descriptors in index order and
// hands each enabled, non-empty one to the single-transfer DMA engine.
module dma_desc_sequencer #(
  parameter int NUM_DESC    = 5,
  parameter int ADDR_WIDTH  = 32,
  parameter int BYTES_WIDTH = 32,
  parameter int BURST_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            go_i,
  input  logic                            abort_i,
  input  logic [BURST_WIDTH-1:0]          max_burst_i,
  input  logic [NUM_DESC*ADDR_WIDTH-1:0]  desc_src_i,
  input  logic [NUM_DESC*ADDR_WIDTH-1:0]  desc_dst_i,
  input  logic [NUM_DESC*BYTES_WIDTH-1:0] desc_bytes_i,
  input  logic [NUM_DESC-1:0]             desc_wr_mode_i,
  input  logic [NUM_DESC-1:0]             desc_rd_mode_i,
  input  logic [NUM_DESC-1:0]             desc_en_i,
  output logic                            eng_valid_o,
  input  logic                            eng_ready_i,
  output logic [ADDR_WIDTH-1:0]           eng_src_o,
  output logic [ADDR_WIDTH-1:0]           eng_dst_o,
  output logic [BYTES_WIDTH-1:0]          eng_bytes_o,
  output logic                            eng_wr_mode_o,
  output logic                            eng_rd_mode_o,
  output logic [BURST_WIDTH-1:0]          eng_max_burst_o,
  output logic                            eng_abort_o,
  input  logic                            eng_done_i,
  input  logic                            eng_error_i,
  input  logic [ADDR_WIDTH-1:0]           eng_error_addr_i,
  input  logic                            eng_error_type_i,
  input  logic                            eng_error_src_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic                            aborted_o,
  output logic [NUM_DESC-1:0]             desc_done_o,
  output logic [ADDR_WIDTH-1:0]           error_addr_o,
  output logic                            error_type_o,
  output logic                            error_src_o,
  output logic [$clog2(NUM_DESC+1)-1:0]   error_desc_o
);

  localparam int IDX_W = $clog2(NUM_DESC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DESC);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_ABORTING, S_FINISH
  } state_t;

  state_t                 state;
  logic                   go_q;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       sel;
  logic                   start;
  logic                   cur_en;
  logic [ADDR_WIDTH-1:0]  cur_src;
  logic [ADDR_WIDTH-1:0]  cur_dst;
  logic [BYTES_WIDTH-1:0] cur_bytes;
  logic                   cur_wr;
  logic                   cur_rd;

  assign start = go_i & ~go_q;

  // idx reaches NUM_DESC at the end of the walk; clamp so the descriptor mux never reads past the arrays
  always_comb begin
    sel       = (idx < LAST_IDX) ? idx : '0;
    cur_src   = desc_src_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
    cur_dst   = desc_dst_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
    cur_bytes = desc_bytes_i[sel*BYTES_WIDTH +: BYTES_WIDTH];
    cur_wr    = desc_wr_mode_i[sel];
    cur_rd    = desc_rd_mode_i[sel];
    cur_en    = desc_en_i[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      go_q            <= 1'b0;
      idx             <= '0;
      eng_valid_o     <= 1'b0;
      eng_src_o       <= '0;
      eng_dst_o       <= '0;
      eng_bytes_o     <= '0;
      eng_wr_mode_o   <= 1'b0;
      eng_rd_mode_o   <= 1'b0;
      eng_max_burst_o <= '0;
      eng_abort_o     <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      aborted_o       <= 1'b0;
      desc_done_o     <= '0;
      error_addr_o    <= '0;
      error_type_o    <= 1'b0;
      error_src_o     <= 1'b0;
      error_desc_o    <= '0;
    end else begin
      go_q <= go_i;
      case (state)
        S_IDLE: begin
          if (start) begin
            done_o          <= 1'b0;
            error_o         <= 1'b0;
            aborted_o       <= 1'b0;
            desc_done_o     <= '0;
            error_addr_o    <= '0;
            error_type_o    <= 1'b0;
            error_src_o     <= 1'b0;
            error_desc_o    <= '0;
            idx             <= '0;
            eng_max_burst_o <= max_burst_i;
            busy_o          <= 1'b1;
            state           <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort_i) begin
            aborted_o <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= S_FINISH;
          end else if (idx == LAST_IDX) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_FINISH;
          end else if (cur_en && (cur_bytes != '0)) begin
            eng_src_o     <= cur_src;
            eng_dst_o     <= cur_dst;
            eng_bytes_o   <= cur_bytes;
            eng_wr_mode_o <= cur_wr;
            eng_rd_mode_o <= cur_rd;
            eng_valid_o   <= 1'b1;
            state         <= S_ISSUE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_ISSUE: begin
          if (abort_i) begin
            eng_valid_o <= 1'b0;
            aborted_o   <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            state       <= S_FINISH;
          end else if (eng_ready_i) begin
            eng_valid_o <= 1'b0;
            state       <= S_WAIT;
          end
        end
        // A completion in the same cycle as abort is consumed here, otherwise ABORTING would wait forever
        S_WAIT: begin
          if (eng_error_i) begin
            error_o      <= 1'b1;
            error_addr_o <= eng_error_addr_i;
            error_type_o <= eng_error_type_i;
            error_src_o  <= eng_error_src_i;
            error_desc_o <= idx;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            state        <= S_FINISH;
          end else if (eng_done_i) begin
            desc_done_o[sel] <= 1'b1;
            idx              <= idx + 1'b1;
            state            <= S_SCAN;
          end else if (abort_i) begin
            eng_abort_o <= 1'b1;
            state       <= S_ABORTING;
          end
        end
        S_ABORTING: begin
          if (eng_done_i || eng_error_i) begin
            eng_abort_o <= 1'b0;
            aborted_o   <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            if (eng_error_i) begin
              error_o      <= 1'b1;
              error_addr_o <= eng_error_addr_i;
              error_type_o <= eng_error_type_i;
              error_src_o  <= eng_error_src_i;
              error_desc_o <= idx;
            end
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
